// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parametrised UART receiver:
//   - parity-mode constants
//   - receiver FSM state encoding
//   - baud divisor helper
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } rx_state_t;

    // Number of system clocks per bit period.
    function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// ---------------------------------------------------------------------------
// uart_rx_filter
// Input conditioning for the UART receiver: synchroniser, 3-sample history
// with majority vote, and falling-edge detect on the synchronised line.
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst    in   asynchronous active-high reset
//   rx         in   raw asynchronous serial input (idles high)
//   bit_val    out  majority of the last three synchronised samples
//   fall_edge  out  synchronised line is 0 now and was 1 one cycle earlier
// ---------------------------------------------------------------------------
module uart_rx_filter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic rx,
    output logic bit_val,
    output logic fall_edge
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic [2:0]             hist_p1;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    // Stage p0: synchroniser chain; stage p1: sample history
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_p0 <= '1;
            hist_p1 <= 3'b111;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], rx};
            hist_p1 <= {hist_p1[1:0], sync_p0[SYNC_STAGES-1]};
        end
    end

    assign bit_val   = majority3(hist_p1);
    // hist_p1[0] holds the previous value of the last synchroniser stage.
    assign fall_edge = ~sync_p0[SYNC_STAGES-1] & hist_p1[0];

endmodule

// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver: configurable data width, optional odd/even
// parity, 1 or 2 stop bits, majority-voted mid-bit sampling, false-start
// rejection and per-frame parity/framing error flags.
//
// Ports:
//   sys_clk     in   system clock, rising edge
//   sys_rst     in   asynchronous active-high reset
//   rx          in   asynchronous serial input (idles high)
//   po_data     out  received word, LSB received first; held between frames
//   po_flag     out  one-cycle strobe qualifying po_data and the error flags
//   parity_err  out  parity mismatch for this frame (pulses with po_flag)
//   frame_err   out  a stop bit was sampled low (pulses with po_flag)
//   busy        out  receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int UART_BPS    = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] po_data,
    output logic                 po_flag,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int HALF         = BAUD_CNT_MAX / 2;
    localparam int CNT_W        = (BAUD_CNT_MAX > 2) ? $clog2(BAUD_CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_STROBE = CNT_W'(HALF - 1);
    localparam logic [3:0]       LAST_BIT   = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST  = 1'(STOP_BITS - 1);

    rx_state_t              state;
    logic [CNT_W-1:0]       baud_cnt;
    logic [3:0]             bit_idx;
    logic                   stop_idx;
    logic                   par_err_acc;
    logic                   frame_acc;
    logic [DATA_BITS-1:0]   shift_p1;
    logic                   bit_val;
    logic                   fall_edge;
    logic                   strobe;

    uart_rx_filter #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_filter (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .rx        (rx),
        .bit_val   (bit_val),
        .fall_edge (fall_edge)
    );

    // Expected-vs-received parity check; never flags when parity is off.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d,
                                             input logic                 pbit);
        logic x;
        x = (^d) ^ pbit;
        if (PARITY == PAR_ODD)
            return ~x;
        else if (PARITY == PAR_EVEN)
            return x;
        else
            return 1'b0;
    endfunction

    assign strobe = (baud_cnt == CNT_STROBE);
    assign busy   = (state != ST_IDLE);

    // Stage p1: data shift register (datapath, not reset)
    always_ff @(posedge sys_clk) begin
        if (state == ST_DATA && strobe)
            shift_p1 <= {bit_val, shift_p1[DATA_BITS-1:1]};
    end

    // Stage p2: control FSM, baud/bit counters and output registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            par_err_acc <= 1'b0;
            frame_acc   <= 1'b0;
            po_data     <= '0;
            po_flag     <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            po_flag    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (state == ST_IDLE)
                baud_cnt <= '0;
            else if (baud_cnt == CNT_LAST)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (fall_edge)
                        state <= ST_START;
                end
                ST_START: begin
                    if (strobe) begin
                        if (bit_val) begin
                            // Line back high at mid start bit: glitch, not a frame.
                            state    <= ST_IDLE;
                            baud_cnt <= '0;
                        end else begin
                            state       <= ST_DATA;
                            bit_idx     <= '0;
                            par_err_acc <= 1'b0;
                            frame_acc   <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (strobe) begin
                        if (bit_idx == LAST_BIT) begin
                            state    <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                            stop_idx <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end
                ST_PAR: begin
                    if (strobe) begin
                        par_err_acc <= parity_mismatch(shift_p1, bit_val);
                        state       <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (strobe) begin
                        if (stop_idx == STOP_LAST) begin
                            // Leave at mid stop bit so an immediately following
                            // start edge is still caught.
                            state      <= ST_IDLE;
                            baud_cnt   <= '0;
                            po_flag    <= 1'b1;
                            po_data    <= shift_p1;
                            parity_err <= par_err_acc;
                            frame_err  <= frame_acc | ~bit_val;
                        end else begin
                            stop_idx  <= 1'b1;
                            frame_acc <= frame_acc | ~bit_val;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_param
// Four receiver instances with different frame formats share one clock and
// reset; each has its own rx line. Frames are composed bit by bit, and the
// expected word/error flags come from a frame-level model of the format.
// ---------------------------------------------------------------------------
module tb_uart_rx_param;

    localparam int CF   = 3_200_000;
    localparam int BPS  = 100_000;
    localparam int BIT  = CF / BPS;
    localparam int HALF = BIT / 2;
    localparam int SYNC = 2;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } rec_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic [3:0] rx      = 4'hF;
    logic [7:0] d0_data, d1_data, d2_data;
    logic [6:0] d3_data;
    logic [3:0] flag, perr, ferr, busy;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int stray = 0;

    int nb[4] = '{8, 8, 8, 7};
    int pm[4] = '{0, 2, 0, 1};
    int ns[4] = '{1, 1, 2, 2};

    rec_t q0[$], q1[$], q2[$], q3[$];

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    uart_rx_param #(.CLK_FREQ(CF), .UART_BPS(BPS), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .SYNC_STAGES(SYNC)) u0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rx(rx[0]), .po_data(d0_data),
        .po_flag(flag[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .busy(busy[0]));
    uart_rx_param #(.CLK_FREQ(CF), .UART_BPS(BPS), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(1), .SYNC_STAGES(SYNC)) u1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rx(rx[1]), .po_data(d1_data),
        .po_flag(flag[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .busy(busy[1]));
    uart_rx_param #(.CLK_FREQ(CF), .UART_BPS(BPS), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(2), .SYNC_STAGES(SYNC)) u2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rx(rx[2]), .po_data(d2_data),
        .po_flag(flag[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .busy(busy[2]));
    uart_rx_param #(.CLK_FREQ(CF), .UART_BPS(BPS), .DATA_BITS(7), .PARITY(1),
                    .STOP_BITS(2), .SYNC_STAGES(SYNC)) u3 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rx(rx[3]), .po_data(d3_data),
        .po_flag(flag[3]), .parity_err(perr[3]), .frame_err(ferr[3]), .busy(busy[3]));

    // Capture every po_flag cycle; error flags outside po_flag are strays.
    always @(negedge sys_clk) begin
        if (flag[0]) q0.push_back('{9'(d0_data), perr[0], ferr[0], cyc});
        if (flag[1]) q1.push_back('{9'(d1_data), perr[1], ferr[1], cyc});
        if (flag[2]) q2.push_back('{9'(d2_data), perr[2], ferr[2], cyc});
        if (flag[3]) q3.push_back('{9'(d3_data), perr[3], ferr[3], cyc});
        for (int i = 0; i < 4; i++)
            if (!flag[i] && (perr[i] || ferr[i])) stray++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int dut);
        case (dut)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic int get_data(input int dut);
        case (dut)
            0: return int'(d0_data);
            1: return int'(d1_data);
            2: return int'(d2_data);
            default: return int'(d3_data);
        endcase
    endfunction

    task automatic pop_rec(input int dut, output rec_t r);
        case (dut)
            0: r = q0.pop_front();
            1: r = q1.pop_front();
            2: r = q2.pop_front();
            default: r = q3.pop_front();
        endcase
    endtask

    // Frame-level reference: parity error when the total count of ones in
    // data plus parity bit has the wrong sense for the mode.
    function automatic int model_perr(input int data, input int nbits,
                                      input int pmode, input int pbit);
        int ones;
        ones = pbit;
        for (int i = 0; i < nbits; i++) ones += (data >> i) & 1;
        if (pmode == 1) return (ones % 2 == 0) ? 1 : 0;
        if (pmode == 2) return (ones % 2 == 1) ? 1 : 0;
        return 0;
    endfunction

    function automatic int model_ferr(input int stop_vals, input int nstop);
        for (int i = 0; i < nstop; i++)
            if (((stop_vals >> i) & 1) == 0) return 1;
        return 0;
    endfunction

    task automatic check_idle_outputs(input int dut, input string tag);
        chk({tag, "_data"}, get_data(dut), 0);
        chk({tag, "_flag"}, int'(flag[dut]), 0);
        chk({tag, "_perr"}, int'(perr[dut]), 0);
        chk({tag, "_ferr"}, int'(ferr[dut]), 0);
        chk({tag, "_busy"}, int'(busy[dut]), 0);
    endtask

    // Drives one frame on rx[dut], starting and ending on a falling clock edge.
    // glitch_bit >= 0 inverts data bit glitch_bit for one cycle at mid-bit;
    // rst_bit >= 0 pulses sys_rst at mid data bit rst_bit and abandons the frame.
    task automatic send_frame(input int dut, input int data, input int pbit,
                              input int stop_vals, input int glitch_bit,
                              input int rst_bit, output int c0);
        logic fb[16];
        int   n;
        n = 0;
        fb[n] = 1'b0; n++;
        for (int i = 0; i < nb[dut]; i++) begin
            fb[n] = ((data >> i) & 1) != 0; n++;
        end
        if (pm[dut] != 0) begin
            fb[n] = (pbit != 0); n++;
        end
        for (int i = 0; i < ns[dut]; i++) begin
            fb[n] = ((stop_vals >> i) & 1) != 0; n++;
        end
        c0 = cyc;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < BIT; j++) begin
                if (rst_bit >= 0 && k == rst_bit + 1 && j == HALF) begin
                    rx[dut] = 1'b1;
                    sys_rst = 1'b1;
                    repeat (3) @(negedge sys_clk);
                    check_idle_outputs(dut, "midrst");
                    sys_rst = 1'b0;
                    return;
                end
                if (glitch_bit >= 0 && k == glitch_bit + 1 && j == HALF)
                    rx[dut] = ~fb[k];
                else
                    rx[dut] = fb[k];
                @(negedge sys_clk);
            end
        end
        rx[dut] = 1'b1;
    endtask

    task automatic check_frame(input int dut, input string tag, input int exp_data,
                               input int exp_perr, input int exp_ferr);
        rec_t r;
        chk({tag, "_present"}, (qsize(dut) > 0) ? 1 : 0, 1);
        if (qsize(dut) > 0) begin
            pop_rec(dut, r);
            chk({tag, "_data"}, int'(r.data), exp_data);
            chk({tag, "_perr"}, int'(r.perr), exp_perr);
            chk({tag, "_ferr"}, int'(r.ferr), exp_ferr);
        end
    endtask

    initial begin
        int   c0;
        int   data, pbit, sv, dut, mask;
        rec_t r;

        // Reset state
        #1 sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        check_idle_outputs(0, "rst0");
        check_idle_outputs(3, "rst3");
        sys_rst = 1'b0;
        repeat (4) @(negedge sys_clk);

        // 8N1 0xA5 with latency check
        send_frame(0, 8'hA5, 0, 1, -1, -1, c0);
        repeat (2) @(negedge sys_clk);
        chk("a5_present", (q0.size() > 0) ? 1 : 0, 1);
        if (q0.size() > 0) begin
            r = q0.pop_front();
            chk("a5_data", int'(r.data), 8'hA5);
            chk("a5_perr", int'(r.perr), 0);
            chk("a5_ferr", int'(r.ferr), 0);
            chk("a5_latency", r.cyc - c0, SYNC + 1 + HALF + 9 * BIT);
        end
        chk("a5_single", q0.size(), 0);
        chk("a5_busy_after", int'(busy[0]), 0);

        // Even parity, 0x3C with wrong then correct parity bit
        send_frame(1, 8'h3C, 1, 1, -1, -1, c0);
        repeat (2) @(negedge sys_clk);
        check_frame(1, "even_bad", 8'h3C, model_perr(8'h3C, 8, 2, 1), 0);
        send_frame(1, 8'h3C, 0, 1, -1, -1, c0);
        repeat (2) @(negedge sys_clk);
        check_frame(1, "even_good", 8'h3C, model_perr(8'h3C, 8, 2, 0), 0);

        // Framing errors
        send_frame(0, 8'h55, 0, 0, -1, -1, c0);
        repeat (BIT) @(negedge sys_clk);
        check_frame(0, "stop_low", 8'h55, 0, 1);
        send_frame(2, 8'h55, 0, 2'b01, -1, -1, c0);
        repeat (BIT) @(negedge sys_clk);
        check_frame(2, "stop2_low", 8'h55, 0, 1);

        // False start: short low pulse on an idle line
        rx[0] = 1'b0;
        repeat (6) @(negedge sys_clk);
        rx[0] = 1'b1;
        chk("fstart_busy", int'(busy[0]), 1);
        repeat (2 * BIT) @(negedge sys_clk);
        chk("fstart_idle", int'(busy[0]), 0);
        chk("fstart_noflag", q0.size(), 0);

        // Single-cycle glitch at mid data bit 3 of 0x00
        send_frame(0, 8'h00, 0, 1, 3, -1, c0);
        repeat (2) @(negedge sys_clk);
        check_frame(0, "glitch", 8'h00, 0, 0);

        // Back-to-back frames
        send_frame(0, 8'h01, 0, 1, -1, -1, c0);
        send_frame(0, 8'hFE, 0, 1, -1, -1, c0);
        repeat (2) @(negedge sys_clk);
        check_frame(0, "b2b_first", 8'h01, 0, 0);
        check_frame(0, "b2b_second", 8'hFE, 0, 0);
        chk("b2b_count", q0.size(), 0);

        // Reset during data bit 4, then a clean frame
        send_frame(0, 8'h81, 0, 1, -1, 4, c0);
        repeat (3 * BIT) @(negedge sys_clk);
        chk("rst8_noflag", q0.size(), 0);
        send_frame(0, 8'h81, 0, 1, -1, -1, c0);
        repeat (2) @(negedge sys_clk);
        check_frame(0, "after_rst8", 8'h81, 0, 0);

        send_frame(3, 7'h5A, 1, 2'b11, -1, 4, c0);
        repeat (3 * BIT) @(negedge sys_clk);
        chk("rst7_noflag", q3.size(), 0);
        send_frame(3, 7'h5A, 1, 2'b11, -1, -1, c0);
        repeat (2) @(negedge sys_clk);
        check_frame(3, "after_rst7", 7'h5A, model_perr(7'h5A, 7, 1, 1), 0);

        // Randomised frames across all four formats
        for (int it = 0; it < 16; it++) begin
            dut  = $urandom_range(0, 3);
            mask = (1 << nb[dut]) - 1;
            data = $urandom_range(0, 511) & mask;
            pbit = $urandom_range(0, 1);
            sv   = 3;
            if ($urandom_range(0, 3) == 0)
                sv = sv & ~(1 << $urandom_range(0, ns[dut] - 1));
            send_frame(dut, data, pbit, sv, -1, -1, c0);
            repeat (BIT) @(negedge sys_clk);
            check_frame(dut, $sformatf("rnd%0d_u%0d", it, dut), data,
                        model_perr(data, nb[dut], pm[dut], pbit),
                        model_ferr(sv, ns[dut]));
            chk($sformatf("rnd%0d_single", it), qsize(dut), 0);
        end

        chk("stray_err_pulses", stray, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
